vec_lane_wb_collector: RTL

Downstream writeback stage for the four-lane vector ALU array. It captures each lane's 64-bit result chunk on that lane's `done` pulse and buffers it in a per-lane skid FIFO. A round-robin arbiter serialises the chunks onto the single 64-bit vector-register-file write port. It counts written chunks against the issued operation and raises a one-cycle completion pulse when the destination register group is fully written.

---
 rtl/vec_pkg.sv | 24 ++
 rtl/vec_lane_fifo.sv | 54 +++++
 rtl/vec_lane_wb_collector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector-lane writeback collector.
package vec_pkg;

    localparam int NB_LANES = 4;
    localparam int CHUNK_W  = 64;
    localparam int REGI_W   = 10;
    localparam int VD_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FINISH  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [REGI_W-1:0]  regi;
        logic [CHUNK_W-1:0] data;
    } wb_entry_t;

    function automatic logic [1:0] rr_next(input logic [1:0] lane);
        return lane + 2'd1;
    endfunction

endpackage

// File: rtl/vec_lane_fifo.sv
// Per-lane synchronous skid FIFO; a push into a full FIFO is accepted when it is popped the same cycle.
module vec_lane_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 74
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == (AW+1)'(0));
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr];

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_count <= (AW+1)'(0);
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/vec_lane_wb_collector.sv
// Collects per-lane vector ALU result chunks and serialises them round-robin onto the VRF write port.
module vec_lane_wb_collector
    import vec_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [VD_W-1:0]     i_vd_sel,
    input  logic [REGI_W-1:0]   i_nb_chunks,
    input  logic [CHUNK_W-1:0]  i_vd0,
    input  logic [CHUNK_W-1:0]  i_vd1,
    input  logic [CHUNK_W-1:0]  i_vd2,
    input  logic [CHUNK_W-1:0]  i_vd3,
    input  logic [REGI_W-1:0]   i_regi0,
    input  logic [REGI_W-1:0]   i_regi1,
    input  logic [REGI_W-1:0]   i_regi2,
    input  logic [REGI_W-1:0]   i_regi3,
    input  logic                i_done0,
    input  logic                i_done1,
    input  logic                i_done2,
    input  logic                i_done3,
    output logic                o_wr_valid,
    input  logic                i_wr_ready,
    output logic [14:0]         o_wr_addr,
    output logic [CHUNK_W-1:0]  o_wr_data,
    output logic                o_busy,
    output logic                o_op_done,
    output logic                o_err_overflow,
    output logic                o_err_stray
);

    if ((VLEN % CHUNK_W) != 0) begin : g_vlen_chk
        $error("VLEN must be a multiple of 64");
    end

    wb_state_e                  r_state, w_state_nxt;
    logic [VD_W-1:0]            r_vd_sel;
    logic [REGI_W-1:0]          r_remaining;
    logic [1:0]                 r_ptr;
    logic                       r_wr_valid, r_busy, r_op_done, r_err_overflow, r_err_stray;
    logic [14:0]                r_wr_addr;
    logic [CHUNK_W-1:0]         r_wr_data;

    logic [NB_LANES-1:0]        w_done, w_full, w_empty, w_pop, w_push;
    wb_entry_t [NB_LANES-1:0]   w_lane_in, w_head;
    logic                       w_collect, w_hs, w_grant_ok, w_any, w_grant, w_ovf, w_stray;
    logic [1:0]                 w_grant_lane, w_scan_idx;
    wb_entry_t                  w_grant_entry;

    assign w_done       = {i_done3, i_done2, i_done1, i_done0};
    assign w_lane_in[0] = {i_regi0, i_vd0};
    assign w_lane_in[1] = {i_regi1, i_vd1};
    assign w_lane_in[2] = {i_regi2, i_vd2};
    assign w_lane_in[3] = {i_regi3, i_vd3};

    assign w_collect = (r_state == ST_COLLECT);
    assign w_hs      = r_wr_valid && i_wr_ready;
    // Only grant while the in-flight chunk count stays below the chunks still owed.
    assign w_grant_ok = w_collect && (!r_wr_valid || i_wr_ready)
                        && ({{(REGI_W-1){1'b0}}, r_wr_valid} < r_remaining);
    assign w_grant       = w_any && w_grant_ok;
    assign w_grant_entry = w_head[w_grant_lane];
    assign w_ovf         = w_collect && |(w_done & w_full & ~w_pop);
    assign w_stray       = !w_collect && |w_done;

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        assign w_pop[k]  = w_grant && (w_grant_lane == 2'(k));
        assign w_push[k] = w_collect && w_done[k] && (!w_full[k] || w_pop[k]);

        vec_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH ($bits(wb_entry_t))
        ) u_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_flush (r_state == ST_FINISH),
            .i_push  (w_push[k]),
            .i_din   (w_lane_in[k]),
            .i_pop   (w_pop[k]),
            .o_dout  (w_head[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k])
        );
    end

    // Round-robin scan starting at the pointer, wrapping over all lanes.
    always_comb begin
        w_any        = 1'b0;
        w_grant_lane = r_ptr;
        w_scan_idx   = 2'd0;
        for (int off = 0; off < NB_LANES; off++) begin
            w_scan_idx   = r_ptr + 2'(off);
            w_grant_lane = (!w_any && !w_empty[w_scan_idx]) ? w_scan_idx : w_grant_lane;
            w_any        = w_any | !w_empty[w_scan_idx];
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = (i_nb_chunks == 10'd0) ? ST_FINISH : ST_COLLECT;
                else         w_state_nxt = ST_IDLE;
            end
            ST_COLLECT: begin
                if (w_hs && (r_remaining == 10'd1)) w_state_nxt = ST_FINISH;
                else                                w_state_nxt = ST_COLLECT;
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state, chunk accounting, arbitration pointer and sticky errors.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_vd_sel       <= 5'd0;
            r_remaining    <= 10'd0;
            r_ptr          <= 2'd0;
            r_busy         <= 1'b0;
            r_op_done      <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_stray    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_op_done <= (w_state_nxt == ST_FINISH);
            if ((r_state == ST_IDLE) && i_start) begin
                r_vd_sel    <= i_vd_sel;
                r_remaining <= i_nb_chunks;
            end else if (w_hs && (r_remaining != 10'd0)) begin
                r_remaining <= r_remaining - 10'd1;
            end
            if (w_grant) r_ptr <= rr_next(w_grant_lane);
            r_err_overflow <= r_err_overflow | w_ovf;
            r_err_stray    <= r_err_stray | w_stray;
        end
    end

    // Output register: loads on grant, clears on a handshake with nothing behind it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 15'd0;
            r_wr_data  <= 64'd0;
        end else if (w_grant) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= {r_vd_sel, w_grant_entry.regi};
            r_wr_data  <= w_grant_entry.data;
        end else if (w_hs) begin
            r_wr_valid <= 1'b0;
        end
    end

    assign o_wr_valid     = r_wr_valid;
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = r_wr_data;
    assign o_busy         = r_busy;
    assign o_op_done      = r_op_done;
    assign o_err_overflow = r_err_overflow;
    assign o_err_stray    = r_err_stray;

endmodule
